// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus write controller:
// FSM state encoding, default bus timing, and the registered output bundle.
package rtc_bus_pkg;

  localparam int T_SU_DEF  = 2;
  localparam int T_WR_DEF  = 8;
  localparam int T_HD_DEF  = 2;
  localparam int T_GAP_DEF = 4;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_A_SU     = 4'd1,
    S_A_WR     = 4'd2,
    S_A_HD     = 4'd3,
    S_GAP      = 4'd4,
    S_D_SU     = 4'd5,
    S_D_WR     = 4'd6,
    S_D_HD     = 4'd7,
    S_DONE     = 4'd8,
    S_WAIT_CLR = 4'd9
  } state_e;

  typedef struct packed {
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       a_d;
    logic       fin_wr;
    logic       busy;
  } bus_out_t;

  localparam bus_out_t BUS_IDLE = '{
    ad_out: 8'h00, ad_oe: 1'b0, cs_n: 1'b1, wr_n: 1'b1,
    rd_n:   1'b1,  a_d:   1'b1, fin_wr: 1'b0, busy: 1'b0
  };

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // The counter is loaded with (param - 1), so clog2(max) bits suffice; keep at least one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

  function automatic bus_out_t decode_outputs(input state_e s, input logic [7:0] addr,
                                              input logic [7:0] data);
    bus_out_t o;
    o      = BUS_IDLE;
    o.busy = (s != S_IDLE);
    case (s)
      S_A_SU, S_A_WR, S_A_HD: begin
        o.cs_n   = 1'b0;
        o.a_d    = 1'b0;
        o.ad_oe  = 1'b1;
        o.ad_out = addr;
        o.wr_n   = (s != S_A_WR);
      end
      S_D_SU, S_D_WR, S_D_HD: begin
        o.cs_n   = 1'b0;
        o.a_d    = 1'b1;
        o.ad_oe  = 1'b1;
        o.ad_out = data;
        o.wr_n   = (s != S_D_WR);
      end
      S_DONE:  o.fin_wr = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing each bus phase; done_o is high once the count reaches zero.
module rtc_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load_i)               count_d = value_i;
    else if (count_q != '0)   count_d = count_q - 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/rtc_bus_write_ctrl.sv
// Executes one address-phase + data-phase write on the RTC multiplexed bus per request,
// then pulses fin_wr and waits for the decoder to drop en_progra.
module rtc_bus_write_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int T_SU  = T_SU_DEF,
  parameter int T_WR  = T_WR_DEF,
  parameter int T_HD  = T_HD_DEF,
  parameter int T_GAP = T_GAP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_progra,
  input  logic       sw,
  input  logic [7:0] addr_in,
  input  logic [7:0] data_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       a_d,
  output logic       fin_wr,
  output logic       busy
);

  localparam int CNT_W = cnt_width(max4(T_SU, T_WR, T_HD, T_GAP));

  localparam logic [CNT_W-1:0] LD_SU  = CNT_W'(T_SU - 1);
  localparam logic [CNT_W-1:0] LD_WR  = CNT_W'(T_WR - 1);
  localparam logic [CNT_W-1:0] LD_HD  = CNT_W'(T_HD - 1);
  localparam logic [CNT_W-1:0] LD_GAP = CNT_W'(T_GAP - 1);

  state_e           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  bus_out_t         out_q;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_done;

  rtc_phase_timer #(.W(CNT_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .done_o  (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      S_IDLE: if (en_progra && sw) begin
        state_d   = S_A_SU;
        addr_d    = addr_in;
        data_d    = data_in;
        tmr_load  = 1'b1;
        tmr_value = LD_SU;
      end
      S_A_SU: if (tmr_done) begin
        state_d = S_A_WR; tmr_load = 1'b1; tmr_value = LD_WR;
      end
      S_A_WR: if (tmr_done) begin
        state_d = S_A_HD; tmr_load = 1'b1; tmr_value = LD_HD;
      end
      S_A_HD: if (tmr_done) begin
        state_d = S_GAP; tmr_load = 1'b1; tmr_value = LD_GAP;
      end
      S_GAP: if (tmr_done) begin
        state_d = S_D_SU; tmr_load = 1'b1; tmr_value = LD_SU;
      end
      S_D_SU: if (tmr_done) begin
        state_d = S_D_WR; tmr_load = 1'b1; tmr_value = LD_WR;
      end
      S_D_WR: if (tmr_done) begin
        state_d = S_D_HD; tmr_load = 1'b1; tmr_value = LD_HD;
      end
      S_D_HD:     if (tmr_done) state_d = S_DONE;
      S_DONE:     state_d = S_WAIT_CLR;
      // Hold here until the decoder drops its stale request level.
      S_WAIT_CLR: if (!en_progra) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Pins are a registered decode of the current state, so they trail the state by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      out_q   <= BUS_IDLE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      out_q   <= decode_outputs(state_q, addr_q, data_q);
    end
  end

  assign ad_out = out_q.ad_out;
  assign ad_oe  = out_q.ad_oe;
  assign cs_n   = out_q.cs_n;
  assign wr_n   = out_q.wr_n;
  assign rd_n   = out_q.rd_n;
  assign a_d    = out_q.a_d;
  assign fin_wr = out_q.fin_wr;
  assign busy   = out_q.busy;

endmodule

// File: tb/tb_rtc_bus_write_ctrl.sv
// Scoreboard bench: expected write strobes are queued when a request is driven and
// compared when the bus monitor sees each wr_n pulse complete.
module tb_rtc_bus_write_ctrl;

  localparam int TW = 8;

  typedef struct {
    logic       a_d;
    logic [7:0] ad;
    int         width;
  } strobe_t;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic [1:0] en_v    = '0;
  logic [1:0] sw_v    = '0;
  logic [7:0] addr_in = '0;
  logic [7:0] data_in = '0;

  logic [7:0] ad_out_w [2];
  logic       ad_oe_w  [2];
  logic       cs_n_w   [2];
  logic       wr_n_w   [2];
  logic       rd_n_w   [2];
  logic       a_d_w    [2];
  logic       fin_w    [2];
  logic       busy_w   [2];

  int checks = 0;
  int errors = 0;
  int fin_cnt [2] = '{0, 0};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  rtc_bus_write_ctrl dut0 (
    .clk(clk), .reset(reset), .en_progra(en_v[0]), .sw(sw_v[0]),
    .addr_in(addr_in), .data_in(data_in),
    .ad_out(ad_out_w[0]), .ad_oe(ad_oe_w[0]), .cs_n(cs_n_w[0]), .wr_n(wr_n_w[0]),
    .rd_n(rd_n_w[0]), .a_d(a_d_w[0]), .fin_wr(fin_w[0]), .busy(busy_w[0])
  );

  rtc_bus_write_ctrl #(.T_GAP(1)) dut1 (
    .clk(clk), .reset(reset), .en_progra(en_v[1]), .sw(sw_v[1]),
    .addr_in(addr_in), .data_in(data_in),
    .ad_out(ad_out_w[1]), .ad_oe(ad_oe_w[1]), .cs_n(cs_n_w[1]), .wr_n(wr_n_w[1]),
    .rd_n(rd_n_w[1]), .a_d(a_d_w[1]), .fin_wr(fin_w[1]), .busy(busy_w[1])
  );

  for (genvar g = 0; g < 2; g++) begin : mon
    strobe_t    q[$];
    logic       prev_wr  = 1'b1;
    logic       prev_cs  = 1'b1;
    logic       prev_a_d = 1'b1;
    logic [7:0] prev_ad  = '0;
    int         low_cnt  = 0;
    strobe_t    seen;
    strobe_t    e;

    always @(negedge clk) begin
      check($sformatf("rd_n_high[%0d]", g), rd_n_w[g], 1'b1);
      if (wr_n_w[g] === 1'b0) begin
        if (prev_wr === 1'b0) begin
          low_cnt++;
          check($sformatf("ad_stable[%0d]", g), ad_out_w[g], prev_ad);
          check($sformatf("cs_stable[%0d]", g), cs_n_w[g], prev_cs);
          check($sformatf("a_d_stable[%0d]", g), a_d_w[g], prev_a_d);
        end else begin
          low_cnt  = 1;
          seen.ad  = ad_out_w[g];
          seen.a_d = a_d_w[g];
          check($sformatf("cs_low_at_fall[%0d]", g), cs_n_w[g], 1'b0);
          check($sformatf("oe_at_fall[%0d]", g), ad_oe_w[g], 1'b1);
          check($sformatf("setup_ad[%0d]", g), ad_out_w[g], prev_ad);
          check($sformatf("setup_cs[%0d]", g), cs_n_w[g], prev_cs);
          check($sformatf("setup_a_d[%0d]", g), a_d_w[g], prev_a_d);
        end
      end else if (prev_wr === 1'b0) begin
        if (!reset) begin
          check($sformatf("hold_ad[%0d]", g), ad_out_w[g], prev_ad);
          check($sformatf("hold_cs[%0d]", g), cs_n_w[g], 1'b0);
        end
        if (q.size() == 0) begin
          check($sformatf("unexpected_strobe[%0d]", g), 1, 0);
        end else begin
          e = q.pop_front();
          check($sformatf("strobe_ad[%0d]", g), seen.ad, e.ad);
          check($sformatf("strobe_a_d[%0d]", g), seen.a_d, e.a_d);
          check($sformatf("strobe_width[%0d]", g), low_cnt, e.width);
        end
      end
      if (fin_w[g] === 1'b1) fin_cnt[g]++;
      prev_wr  = wr_n_w[g];
      prev_cs  = cs_n_w[g];
      prev_a_d = a_d_w[g];
      prev_ad  = ad_out_w[g];
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input int g, input logic [7:0] a, input logic [7:0] d, input int dw);
    strobe_t s;
    s.a_d = 1'b0; s.ad = a; s.width = TW;
    if (g == 0) mon[0].q.push_back(s); else mon[1].q.push_back(s);
    s.a_d = 1'b1; s.ad = d; s.width = dw;
    if (g == 0) mon[0].q.push_back(s); else mon[1].q.push_back(s);
  endtask

  task automatic check_idle(input int g);
    check($sformatf("idle_ad_out[%0d]", g), ad_out_w[g], 8'h00);
    check($sformatf("idle_ad_oe[%0d]", g), ad_oe_w[g], 1'b0);
    check($sformatf("idle_cs_n[%0d]", g), cs_n_w[g], 1'b1);
    check($sformatf("idle_wr_n[%0d]", g), wr_n_w[g], 1'b1);
    check($sformatf("idle_a_d[%0d]", g), a_d_w[g], 1'b1);
    check($sformatf("idle_fin_wr[%0d]", g), fin_w[g], 1'b0);
    check($sformatf("idle_busy[%0d]", g), busy_w[g], 1'b0);
  endtask

  // Drive one request, act as the decoder (drop en_progra after fin_wr, optionally late).
  task automatic run_txn(input int g, input logic [7:0] a, input logic [7:0] d, input int lat,
                         input bit mid_change, input int hold);
    int n;
    int f0;
    push_exp(g, a, d, TW);
    f0      = fin_cnt[g];
    addr_in = a;
    data_in = d;
    en_v[g] = 1'b1;
    sw_v[g] = 1'b1;
    tick(1);
    n = 0;
    while (fin_w[g] !== 1'b1 && n < 100) begin
      tick(1);
      n++;
      if (mid_change && n == 5) begin
        addr_in = 8'h41;
        data_in = 8'hAA;
      end
      if (mid_change && n == 6) sw_v[g] = 1'b0;
    end
    check($sformatf("fin_latency[%0d]", g), n, lat);
    if (hold > 0) begin
      tick(hold);
      check($sformatf("wait_clr_busy[%0d]", g), busy_w[g], 1'b1);
      check($sformatf("no_restart[%0d]", g), (g == 0) ? mon[0].q.size() : mon[1].q.size(), 0);
    end
    en_v[g] = 1'b0;
    sw_v[g] = 1'b0;
    tick(2);
    check($sformatf("busy_cleared[%0d]", g), busy_w[g], 1'b0);
    check($sformatf("fin_pulses[%0d]", g), fin_cnt[g] - f0, 1);
  endtask

  initial begin
    int f0;
    tick(3);
    check_idle(0);
    check_idle(1);
    reset = 1'b0;
    tick(2);
    check_idle(0);

    run_txn(0, 8'h24, 8'h15, 29, 1'b0, 0);
    run_txn(0, 8'h24, 8'h15, 29, 1'b0, 10);
    run_txn(0, 8'h24, 8'h15, 29, 1'b1, 0);
    run_txn(1, 8'h24, 8'h15, 26, 1'b0, 0);

    en_v[0] = 1'b1;
    sw_v[0] = 1'b0;
    tick(10);
    check_idle(0);
    en_v[0] = 1'b0;
    tick(1);

    // Reset lands mid data strobe: three low cycles seen, then the bus snaps idle.
    push_exp(0, 8'h24, 8'h15, 3);
    f0      = fin_cnt[0];
    addr_in = 8'h24;
    data_in = 8'h15;
    en_v[0] = 1'b1;
    sw_v[0] = 1'b1;
    tick(1);
    tick(21);
    reset   = 1'b1;
    en_v[0] = 1'b0;
    sw_v[0] = 1'b0;
    tick(1);
    check("rst_wr_n", wr_n_w[0], 1'b1);
    check("rst_cs_n", cs_n_w[0], 1'b1);
    check("rst_ad_oe", ad_oe_w[0], 1'b0);
    check("rst_busy", busy_w[0], 1'b0);
    tick(2);
    reset = 1'b0;
    tick(5);
    check("rst_no_fin", fin_cnt[0] - f0, 0);
    check_idle(0);

    tick(3);
    check("queue_empty[0]", mon[0].q.size(), 0);
    check("queue_empty[1]", mon[1].q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
